or1200_wb_cmd_master: RTL and testbench

OR1200_WB_CMD_MASTER -- requirements
Module: or1200_wb_cmd_master

---
 rtl/or1200_tb_wb_pkg.sv | 36 +++
 rtl/or1200_wb_cmd_master.sv | 223 ++++++++++++++++++++++
 tb/tb_or1200_wb_cmd_master.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/or1200_tb_wb_pkg.sv
// ---------------------------------------------------------------------------
// or1200_tb_wb_pkg
// Shared definitions for the Wishbone command master:
//   state_t      - master FSM states (IDLE, ACTIVE, RSP, BACKOFF)
//   CTI_*        - Wishbone B3 cycle type identifiers
//   BTE_LINEAR   - burst type extension (linear only)
//   burstCti()   - cycle type for the next beat of a command
// ---------------------------------------------------------------------------
package or1200_tb_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RSP     = 2'd2,
    ST_BACKOFF = 2'd3
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Cycle type for an upcoming beat: classic for single transfers,
  // incrementing for burst beats, end-of-burst for the final burst beat.
  function automatic logic [2:0] burstCti(input logic isBurst,
                                          input logic isLastBeat);
    logic [2:0] cti;
    cti = CTI_CLASSIC;
    if (isBurst) begin
      cti = isLastBeat ? CTI_EOB : CTI_INCR;
    end
    return cti;
  endfunction

endpackage

// File: rtl/or1200_wb_cmd_master.sv
// ---------------------------------------------------------------------------
// or1200_wb_cmd_master
// Turns simple commands (single-beat write, or incrementing read burst of
// 1..16 beats) into Wishbone B3 master cycles and returns one response per
// beat. Handles slave err/rty terminations and a per-beat timeout.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_we, cmd_adr, cmd_dat,
//   cmd_sel, cmd_len                 command fields (len = read beats - 1)
//   rsp_valid/rsp_ready              response handshake
//   rsp_dat, rsp_err, rsp_last       response fields
//   wb_cyc_o, wb_stb_o, wb_we_o,
//   wb_adr_o, wb_dat_o, wb_sel_o,
//   wb_cti_o, wb_bte_o               registered Wishbone master outputs
//   wb_ack_i, wb_err_i, wb_rty_i,
//   wb_dat_i                         Wishbone slave terminations and data
// ---------------------------------------------------------------------------
module or1200_wb_cmd_master
  import or1200_tb_wb_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  input  logic [3:0]  cmd_len,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_last,

  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  input  logic [31:0] wb_dat_i
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] RTY_MAX  = 16'(MAX_RETRY);

  state_t      r_state;
  logic        r_cyc;
  logic        r_stb;
  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic [2:0]  r_cti;
  logic        r_rspValid;
  logic [31:0] r_rspDat;
  logic        r_rspErr;
  logic        r_rspLast;
  logic [3:0]  r_beatsLeft;
  logic [15:0] r_tmo;
  logic [15:0] r_rty;

  logic        w_termErr;
  logic        w_termAck;
  logic        w_termRty;
  logic        w_noTerm;
  logic        w_lastBeat;
  logic        w_fail;
  logic        w_isBurst;
  logic        w_unused;

  // err dominates, ack beats rty, rty only counts when alone.
  assign w_termErr  = wb_err_i;
  assign w_termAck  = wb_ack_i & ~wb_err_i;
  assign w_termRty  = wb_rty_i & ~wb_ack_i & ~wb_err_i;
  assign w_noTerm   = ~wb_ack_i & ~wb_err_i & ~wb_rty_i;
  assign w_lastBeat = (r_beatsLeft == 4'd0);
  assign w_isBurst  = (r_cti != CTI_CLASSIC);

  // Any of these ends the command with an error response.
  assign w_fail = w_termErr
                | (w_termRty & (r_rty >= RTY_MAX))
                | (w_noTerm  & (r_tmo >= TMO_LAST));

  // Address bits [1:0] are ignored; the bus address is always word aligned.
  assign w_unused = &{1'b0, cmd_adr[1:0]};

  assign cmd_ready = (r_state == ST_IDLE) && !rst;

  assign rsp_valid = r_rspValid;
  assign rsp_dat   = r_rspDat;
  assign rsp_err   = r_rspErr;
  assign rsp_last  = r_rspLast;

  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_stb;
  assign wb_we_o   = r_we;
  assign wb_adr_o  = r_adr;
  assign wb_dat_o  = r_dat;
  assign wb_sel_o  = r_sel;
  assign wb_cti_o  = r_cti;
  assign wb_bte_o  = BTE_LINEAR;

  // Master FSM. Every bus and response output is a register written here,
  // so the slave may terminate combinationally without creating a loop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= 32'd0;
      r_dat       <= 32'd0;
      r_sel       <= 4'd0;
      r_cti       <= CTI_CLASSIC;
      r_rspValid  <= 1'b0;
      r_rspDat    <= 32'd0;
      r_rspErr    <= 1'b0;
      r_rspLast   <= 1'b0;
      r_beatsLeft <= 4'd0;
      r_tmo       <= 16'd0;
      r_rty       <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_state     <= ST_ACTIVE;
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
            r_we        <= cmd_we;
            r_adr       <= {cmd_adr[31:2], 2'b00};
            r_dat       <= cmd_dat;
            r_sel       <= cmd_we ? cmd_sel : 4'hF;
            r_beatsLeft <= cmd_we ? 4'd0 : cmd_len;
            r_cti       <= burstCti(!cmd_we && (cmd_len != 4'd0),
                                    1'b0);
            r_tmo       <= 16'd0;
            r_rty       <= 16'd0;
          end
        end

        ST_ACTIVE: begin
          if (w_fail) begin
            // Abandon the rest of the command; cyc drops with the response.
            r_state     <= ST_RSP;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rspValid  <= 1'b1;
            r_rspDat    <= 32'd0;
            r_rspErr    <= 1'b1;
            r_rspLast   <= 1'b1;
            r_beatsLeft <= 4'd0;
          end else if (w_termAck) begin
            r_state    <= ST_RSP;
            r_stb      <= 1'b0;
            // cyc is held across the response only while beats remain.
            r_cyc      <= !w_lastBeat;
            r_rspValid <= 1'b1;
            r_rspDat   <= r_we ? 32'd0 : wb_dat_i;
            r_rspErr   <= 1'b0;
            r_rspLast  <= w_lastBeat;
            r_adr      <= r_adr + 32'd4;
            r_rty      <= 16'd0;
            if (!w_lastBeat) begin
              r_beatsLeft <= r_beatsLeft - 4'd1;
              r_cti       <= burstCti(w_isBurst, r_beatsLeft == 4'd1);
            end
          end else if (w_termRty) begin
            r_state <= ST_BACKOFF;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_rty   <= r_rty + 16'd1;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end

        ST_BACKOFF: begin
          // Reissue the same beat after a single idle bus cycle.
          r_state <= ST_ACTIVE;
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_tmo   <= 16'd0;
        end

        ST_RSP: begin
          if (rsp_ready) begin
            r_rspValid <= 1'b0;
            // A held cyc means more beats of this command are pending.
            if (r_cyc) begin
              r_state <= ST_ACTIVE;
              r_stb   <= 1'b1;
              r_tmo   <= 16'd0;
              r_rty   <= 16'd0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_or1200_wb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_or1200_wb_cmd_master
// Directed bench for or1200_wb_cmd_master with a configurable Wishbone slave
// (immediate ack, err on a chosen beat, N retries, or silent). Read data is
// the address XOR 32'hA5A50000; writes land in a small word memory.
// ---------------------------------------------------------------------------
module tb_or1200_wb_cmd_master;
  import or1200_tb_wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic [3:0]  cmd_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_last;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;
  logic [31:0] wb_dat_i;

  int total = 0;
  int bad   = 0;

  // Slave controls, driven only by the stimulus block.
  logic sClr;
  logic sSilent;
  int   sErrBeat;
  int   sRtyTarget;

  // Slave bookkeeping, written only by the slave process.
  int          ackCnt;
  int          rtyCnt;
  int          stbCycles;
  int          cycRises;
  int          cycleCnt;
  logic        prevCyc;
  logic [31:0] mem [0:255];
  logic [31:0] adrLog [$];
  logic [2:0]  ctiLog [$];
  logic [3:0]  selLog [$];
  logic        weLog [$];
  int          stampLog [$];
  logic [31:0] rspDat [$];
  logic        rspErr [$];
  logic        rspLast [$];

  logic wActive;

  or1200_wb_cmd_master #(.TIMEOUT(8), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_last(rsp_last),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .wb_dat_i(wb_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational slave terminations.
  assign wActive  = wb_cyc_o & wb_stb_o;
  assign wb_err_i = wActive & ~sSilent & (ackCnt == sErrBeat);
  assign wb_rty_i = wActive & ~sSilent & ~wb_err_i & (rtyCnt < sRtyTarget);
  assign wb_ack_i = wActive & ~sSilent & ~wb_err_i & ~wb_rty_i;
  assign wb_dat_i = wb_adr_o ^ 32'hA5A5_0000;

  // Slave memory, bus-cycle logging and response capture.
  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    prevCyc  <= wb_cyc_o;
    if (sClr) begin
      ackCnt    <= 0;
      rtyCnt    <= 0;
      stbCycles <= 0;
      cycRises  <= 0;
      adrLog.delete();
      ctiLog.delete();
      selLog.delete();
      weLog.delete();
      stampLog.delete();
      rspDat.delete();
      rspErr.delete();
      rspLast.delete();
    end else begin
      if (wb_cyc_o && !prevCyc) cycRises <= cycRises + 1;
      if (wActive) begin
        stbCycles <= stbCycles + 1;
        adrLog.push_back(wb_adr_o);
        ctiLog.push_back(wb_cti_o);
        selLog.push_back(wb_sel_o);
        weLog.push_back(wb_we_o);
        stampLog.push_back(cycleCnt);
      end
      if (wb_ack_i) begin
        ackCnt <= ackCnt + 1;
        if (wb_we_o) mem[wb_adr_o[9:2]] <= wb_dat_o;
      end
      if (wb_rty_i) rtyCnt <= rtyCnt + 1;
      if (rsp_valid && rsp_ready) begin
        rspDat.push_back(rsp_dat);
        rspErr.push_back(rsp_err);
        rspLast.push_back(rsp_last);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearSlave();
    sClr = 1'b1;
    @(posedge clk);
    #1 sClr = 1'b0;
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel,
                               input logic [3:0] len);
    int k;
    k = 0;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input int n);
    int k;
    k = 0;
    while (rspDat.size() < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rsp_count", 32'(rspDat.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    rst        = 1'b1;
    sClr       = 1'b1;
    sSilent    = 1'b0;
    sErrBeat   = -1;
    sRtyTarget = 0;
    cmd_valid  = 1'b0;
    cmd_we     = 1'b0;
    cmd_adr    = 32'd0;
    cmd_dat    = 32'd0;
    cmd_sel    = 4'd0;
    cmd_len    = 4'd0;
    rsp_ready  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_cyc", 32'(wb_cyc_o), 32'd0);
    checkOutput("rst_stb", 32'(wb_stb_o), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_adr", wb_adr_o, 32'd0);
    checkOutput("rst_sel", 32'(wb_sel_o), 32'd0);
    checkOutput("rst_cti", 32'(wb_cti_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    sClr = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single write, immediate ack
    clearSlave();
    applyStimulus(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 4'd0);
    waitRsp(1);
    checkOutput("wr_stb_cycles", 32'(stbCycles), 32'd1);
    checkOutput("wr_cti", 32'(ctiLog[0]), 32'(CTI_CLASSIC));
    checkOutput("wr_we", 32'(weLog[0]), 32'd1);
    checkOutput("wr_rsp_err", 32'(rspErr[0]), 32'd0);
    checkOutput("wr_rsp_last", 32'(rspLast[0]), 32'd1);
    checkOutput("wr_rsp_dat", rspDat[0], 32'd0);
    checkOutput("wr_mem", mem[8'h40], 32'hDEAD_BEEF);
    checkOutput("wr_cyc_after", 32'(wb_cyc_o), 32'd0);

    // Four-beat read burst with a two-cycle response stall after beat 1
    clearSlave();
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'h0000_0200, 32'h0, 4'h0, 4'd3);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("burst_rsp1_valid", 32'(rsp_valid), 32'd1);
    checkOutput("burst_stall1_stb", 32'(wb_stb_o), 32'd0);
    checkOutput("burst_stall1_cyc", 32'(wb_cyc_o), 32'd1);
    @(negedge clk);
    checkOutput("burst_stall2_stb", 32'(wb_stb_o), 32'd0);
    checkOutput("burst_stall2_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    waitRsp(4);
    checkOutput("burst_stb_cycles", 32'(stbCycles), 32'd4);
    checkOutput("burst_adr0", adrLog[0], 32'h0000_0200);
    checkOutput("burst_adr1", adrLog[1], 32'h0000_0204);
    checkOutput("burst_adr2", adrLog[2], 32'h0000_0208);
    checkOutput("burst_adr3", adrLog[3], 32'h0000_020C);
    checkOutput("burst_cti0", 32'(ctiLog[0]), 32'h2);
    checkOutput("burst_cti1", 32'(ctiLog[1]), 32'h2);
    checkOutput("burst_cti2", 32'(ctiLog[2]), 32'h2);
    checkOutput("burst_cti3", 32'(ctiLog[3]), 32'h7);
    checkOutput("burst_sel", 32'(selLog[0]), 32'hF);
    checkOutput("burst_we", 32'(weLog[0]), 32'd0);
    checkOutput("burst_dat0", rspDat[0], 32'hA5A5_0200);
    checkOutput("burst_dat1", rspDat[1], 32'hA5A5_0204);
    checkOutput("burst_dat2", rspDat[2], 32'hA5A5_0208);
    checkOutput("burst_dat3", rspDat[3], 32'hA5A5_020C);
    checkOutput("burst_last0", 32'(rspLast[0]), 32'd0);
    checkOutput("burst_last2", 32'(rspLast[2]), 32'd0);
    checkOutput("burst_last3", 32'(rspLast[3]), 32'd1);
    checkOutput("burst_err3", 32'(rspErr[3]), 32'd0);
    checkOutput("burst_cyc_after", 32'(wb_cyc_o), 32'd0);

    // Read burst with err on the second beat
    clearSlave();
    sErrBeat = 1;
    applyStimulus(1'b0, 32'h0000_0280, 32'h0, 4'h0, 4'd3);
    waitRsp(2);
    repeat (3) @(negedge clk);
    checkOutput("err_rsp_count", 32'(rspDat.size()), 32'd2);
    checkOutput("err_rsp0_err", 32'(rspErr[0]), 32'd0);
    checkOutput("err_rsp0_last", 32'(rspLast[0]), 32'd0);
    checkOutput("err_rsp1_err", 32'(rspErr[1]), 32'd1);
    checkOutput("err_rsp1_last", 32'(rspLast[1]), 32'd1);
    checkOutput("err_rsp1_dat", rspDat[1], 32'd0);
    checkOutput("err_stb_cycles", 32'(stbCycles), 32'd2);
    checkOutput("err_cyc", 32'(wb_cyc_o), 32'd0);
    checkOutput("err_idle", 32'(cmd_ready), 32'd1);
    sErrBeat = -1;

    // Single read, two retries then ack
    clearSlave();
    sRtyTarget = 2;
    applyStimulus(1'b0, 32'h0000_0300, 32'h0, 4'h0, 4'd0);
    waitRsp(1);
    checkOutput("rty2_stb_cycles", 32'(stbCycles), 32'd3);
    checkOutput("rty2_cyc_rises", 32'(cycRises), 32'd3);
    checkOutput("rty2_gap0", 32'(stampLog[1] - stampLog[0]), 32'd2);
    checkOutput("rty2_gap1", 32'(stampLog[2] - stampLog[1]), 32'd2);
    checkOutput("rty2_adr1", adrLog[1], 32'h0000_0300);
    checkOutput("rty2_adr2", adrLog[2], 32'h0000_0300);
    checkOutput("rty2_rsp_err", 32'(rspErr[0]), 32'd0);
    checkOutput("rty2_rsp_dat", rspDat[0], 32'hA5A5_0300);

    // Single read, four retries exceed the retry limit
    clearSlave();
    sRtyTarget = 4;
    applyStimulus(1'b0, 32'h0000_0310, 32'h0, 4'h0, 4'd0);
    waitRsp(1);
    checkOutput("rty4_stb_cycles", 32'(stbCycles), 32'd4);
    checkOutput("rty4_rsp_err", 32'(rspErr[0]), 32'd1);
    checkOutput("rty4_rsp_last", 32'(rspLast[0]), 32'd1);
    checkOutput("rty4_rsp_dat", rspDat[0], 32'd0);
    sRtyTarget = 0;

    // Silent slave hits the timeout
    clearSlave();
    sSilent = 1'b1;
    applyStimulus(1'b0, 32'h0000_0400, 32'h0, 4'h0, 4'd0);
    waitRsp(1);
    checkOutput("tmo_stb_cycles", 32'(stbCycles), 32'd8);
    checkOutput("tmo_rsp_err", 32'(rspErr[0]), 32'd1);
    checkOutput("tmo_rsp_last", 32'(rspLast[0]), 32'd1);
    checkOutput("tmo_idle", 32'(cmd_ready), 32'd1);
    sSilent = 1'b0;

    // Reset during beat 2 of a 4-beat read
    clearSlave();
    applyStimulus(1'b0, 32'h0000_0500, 32'h0, 4'h0, 4'd3);
    k = 0;
    while (!(wb_stb_o && ackCnt == 1) && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("mid_beat2_stb", 32'(wb_stb_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
    checkOutput("mid_rst_stb", 32'(wb_stb_o), 32'd0);
    checkOutput("mid_rst_adr", wb_adr_o, 32'd0);
    checkOutput("mid_rst_cti", 32'(wb_cti_o), 32'd0);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_post_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("mid_rsp_count", 32'(rspDat.size()), 32'd1);

    // Normal write after the abandoned burst
    clearSlave();
    applyStimulus(1'b1, 32'h0000_0104, 32'h1234_5678, 4'h3, 4'd9);
    waitRsp(1);
    checkOutput("wr2_stb_cycles", 32'(stbCycles), 32'd1);
    checkOutput("wr2_sel", 32'(selLog[0]), 32'h3);
    checkOutput("wr2_cti", 32'(ctiLog[0]), 32'(CTI_CLASSIC));
    checkOutput("wr2_rsp_last", 32'(rspLast[0]), 32'd1);
    checkOutput("wr2_mem", mem[8'h41], 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
